pl_mem_engine: RTL and testbench
================================

// Module: pl_mem_engine
// PURPOSE
//   PL-side memory master on the shared PS/PL buffer: the PL end of the PS/PL memory-sharing handshake.
//   On launch_pl it reads LEN source words, computes a 32-bit running (prefix) sum, and writes each partial sum back.
//   Drives we_pl/address_pl/data_in_pl toward the PS/PL memory mux; raises finish_pl to hand the memory back to PS.
// PARAMETERS
//   DATA_W    32        memory word width
//   ADDR_W    8         memory address width
//   SRC_BASE  8'd0      first source word address
//   DST_BASE  8'd128    first destination word address
//   LEN       16        words per job, legal 1..256
// PORTS
//   clk          in   1       system clock, rising edge
//   rst          in   1       asynchronous reset, active low
//   ready_for_pl in   1       PS has loaded source data; held high for whole job
//   launch_pl    in   1       memory granted to PL (mux output)
//   mem_rdata    in   DATA_W  memory read data, valid 1 cycle after address presented with we=0
//   we_pl        out  1       write enable toward mux
//   address_pl   out  ADDR_W  address toward mux
//   data_in_pl   out  DATA_W  write data toward mux
//   finish_pl    out  1       job complete; memory returned to PS
//   busy         out  1       job in progress (RD_REQ/RD_WAIT/WR)
// BEHAVIOUR
//   Reset (rst=0, async): state=IDLE; we_pl=0, address_pl=0, data_in_pl=0, finish_pl=0, busy=0, idx=0, acc=0.
//   All outputs registered. FSM states:
//   IDLE:    launch_pl=1 -> RD_REQ, idx=0, acc=0. Else stay; outputs 0.
//   RD_REQ:  address_pl=SRC_BASE+idx, we_pl=0 -> RD_WAIT.
//   RD_WAIT: mem_rdata valid; acc <= acc + mem_rdata -> WR.
//   WR:      we_pl=1 (1 cycle), address_pl=DST_BASE+idx, data_in_pl=acc.
//            idx==LEN-1 -> DONE; else idx++ -> RD_REQ.
//   DONE:    finish_pl=1, we_pl=0; held while ready_for_pl=1. ready_for_pl=0 -> IDLE, finish_pl=0.
//   Latency: 3 cycles/word; finish_pl rises 3*LEN cycles after the first RD_REQ cycle.
//   Address arithmetic modulo 2^ADDR_W (base+idx wraps 255->0). idx counter is ADDR_W+1 bits so LEN=256 is legal.
//   Sum arithmetic: DATA_W-bit, wraps modulo 2^DATA_W (unless PL_SAT_EN).
//   Abort: launch_pl=0 in RD_REQ/RD_WAIT/WR (before finish) -> IDLE next cycle, we_pl=0, finish_pl not raised; partial writes stay.
//   Note: finish_pl=1 makes the mux drop launch_pl; launch_pl=0 in DONE is expected and ignored.
//   ready_for_pl=0 while launch_pl=1 in IDLE: no start (launch_pl implies ready_for_pl; guard anyway).
//   Second job needs ready_for_pl low->high (DONE->IDLE->launch).
// CONFIGURATION
//   PL_SAT_EN defined: unsigned saturating accumulate; acc clamps at 2^DATA_W-1 and stays there.
//   PL_SAT_EN undefined: plain wrap-around add.
// STRUCTURE
//   Shared package/header pl_mem_pkg: FSM state encodings (IDLE/RD_REQ/RD_WAIT/WR/DONE), default SRC_BASE/DST_BASE/LEN.
//   One sub-module: pl_accum (acc register + wrap/saturating adder under PL_SAT_EN; clear, enable inputs).
// TESTING
//   Reset mid-job (rst low in WR) -> all outputs 0 same cycle, IDLE after release, no write.
//   LEN=4, mem[0..3]={1,2,3,4} -> writes mem[128..131]={1,3,6,10}, we_pl pulses 4x, finish_pl at cycle 12.
//   SRC_BASE=254, LEN=4 -> reads addr 254,255,0,1 (wrap), writes DST_BASE..+3.
//   mem={32'hFFFF_FFFF,32'h2}: no PL_SAT_EN -> 32'hFFFF_FFFF,32'h1; PL_SAT_EN -> 32'hFFFF_FFFF,32'hFFFF_FFFF.
//   launch_pl dropped in RD_WAIT of word 2 -> IDLE, only 2 writes seen, finish_pl stays 0.
//   Back-to-back jobs: ready_for_pl held -> finish_pl held; drop then reassert -> second job results correct, acc cleared.

Source files
------------

// File: rtl/pl_mem_pkg.sv
// Shared definitions for the PL memory engine: FSM state encoding and default job geometry.
// Used by pl_mem_engine and pl_accum.
package pl_mem_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_REQ  = 3'd1,
        ST_RD_WAIT = 3'd2,
        ST_WR      = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    localparam int unsigned DEF_DATA_W   = 32;
    localparam int unsigned DEF_ADDR_W   = 8;
    localparam int unsigned DEF_SRC_BASE = 0;
    localparam int unsigned DEF_DST_BASE = 128;
    localparam int unsigned DEF_LEN      = 16;

endpackage

// File: rtl/pl_accum.sv
// Running-sum accumulator with synchronous clear and enable.
// Build option PL_SAT_EN: unsigned saturating add instead of modulo 2^DATA_W wrap-around.
module pl_accum #(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              en,
    input  logic [DATA_W-1:0] add_val,
    output logic [DATA_W-1:0] sum
);

    logic [DATA_W-1:0] acc;

`ifdef PL_SAT_EN
    logic [DATA_W:0] wide_sum;

    assign wide_sum = {1'b0, acc} + {1'b0, add_val};
    // Once the carry fires the result is pinned at all-ones; further adds keep it there.
    assign sum      = wide_sum[DATA_W] ? '1 : wide_sum[DATA_W-1:0];
`else
    assign sum = acc + add_val;
`endif

    // NOTE: async active-low reset; sequential state is written only with non-blocking assignments.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= sum;
        end
    end

endmodule

// File: rtl/pl_mem_engine.sv
// PL-side master on the shared PS/PL buffer: reads LEN words, writes back their running prefix sums.
// Build option PL_SAT_EN (in pl_accum): saturating instead of wrap-around accumulation.
module pl_mem_engine
    import pl_mem_pkg::*;
#(
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned ADDR_W   = DEF_ADDR_W,
    parameter int unsigned SRC_BASE = DEF_SRC_BASE,
    parameter int unsigned DST_BASE = DEF_DST_BASE,
    parameter int unsigned LEN      = DEF_LEN
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ready_for_pl,
    input  logic              launch_pl,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              we_pl,
    output logic [ADDR_W-1:0] address_pl,
    output logic [DATA_W-1:0] data_in_pl,
    output logic              finish_pl,
    output logic              busy
);

    localparam logic [ADDR_W:0]   LAST_IDX = (ADDR_W+1)'(LEN - 1);
    localparam logic [ADDR_W-1:0] SRC_A    = ADDR_W'(SRC_BASE);
    localparam logic [ADDR_W-1:0] DST_A    = ADDR_W'(DST_BASE);

    state_t            state, state_nxt;
    logic [ADDR_W:0]   idx, idx_nxt;
    logic              acc_clr, acc_en;
    logic [DATA_W-1:0] acc_sum;

    pl_accum #(.DATA_W(DATA_W)) u_accum (
        .clk     (clk),
        .rst     (rst),
        .clr     (acc_clr),
        .en      (acc_en),
        .add_val (mem_rdata),
        .sum     (acc_sum)
    );

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        acc_clr   = 1'b0;
        acc_en    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (launch_pl && ready_for_pl) begin
                    state_nxt = ST_RD_REQ;
                    idx_nxt   = '0;
                    acc_clr   = 1'b1;
                end
            end
            ST_RD_REQ: begin
                state_nxt = launch_pl ? ST_RD_WAIT : ST_IDLE;
            end
            ST_RD_WAIT: begin
                if (launch_pl) begin
                    acc_en    = 1'b1;
                    state_nxt = ST_WR;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_WR: begin
                if (!launch_pl) begin
                    state_nxt = ST_IDLE;
                end else if (idx == LAST_IDX) begin
                    state_nxt = ST_DONE;
                end else begin
                    idx_nxt   = idx + (ADDR_W+1)'(1);
                    state_nxt = ST_RD_REQ;
                end
            end
            ST_DONE: begin
                // The mux drops launch_pl once finish_pl is seen, so only ready_for_pl releases DONE.
                if (!ready_for_pl) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            idx        <= '0;
            we_pl      <= 1'b0;
            address_pl <= '0;
            data_in_pl <= '0;
            finish_pl  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state     <= state_nxt;
            idx       <= idx_nxt;
            we_pl     <= (state_nxt == ST_WR);
            finish_pl <= (state_nxt == ST_DONE);
            busy      <= (state_nxt == ST_RD_REQ) || (state_nxt == ST_RD_WAIT) ||
                         (state_nxt == ST_WR);
            case (state_nxt)
                ST_RD_REQ: address_pl <= SRC_A + idx_nxt[ADDR_W-1:0];
                ST_WR:     address_pl <= DST_A + idx[ADDR_W-1:0];
                default:   address_pl <= '0;
            endcase
            data_in_pl <= (state_nxt == ST_WR) ? acc_sum : '0;
        end
    end

endmodule

// File: tb/tb_pl_mem_engine.sv
// Self-checking bench for pl_mem_engine: behavioural memory, write scoreboard, per-scenario tasks.
// Expected sums follow the PL_SAT_EN build option when it is defined.
module tb_pl_mem_engine;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 8;
    localparam int SRC    = 254;
    localparam int DST    = 128;
    localparam int LEN    = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              ready_for_pl;
    logic              launch_pl;
    logic [DATA_W-1:0] mem_rdata;
    logic              we_pl;
    logic [ADDR_W-1:0] address_pl;
    logic [DATA_W-1:0] data_in_pl;
    logic              finish_pl;
    logic              busy;

    always #5 clk = ~clk;

    pl_mem_engine #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .SRC_BASE (SRC),
        .DST_BASE (DST),
        .LEN      (LEN)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .ready_for_pl (ready_for_pl),
        .launch_pl    (launch_pl),
        .mem_rdata    (mem_rdata),
        .we_pl        (we_pl),
        .address_pl   (address_pl),
        .data_in_pl   (data_in_pl),
        .finish_pl    (finish_pl),
        .busy         (busy)
    );

    // Shared buffer model: registered read, write port for the DUT, load port for the bench.
    logic [DATA_W-1:0] mem [256];
    logic              ld_en;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_data;

    always @(posedge clk) begin
        mem_rdata <= mem[address_pl];
        if (we_pl) mem[address_pl] <= data_in_pl;
        if (ld_en) mem[ld_addr] <= ld_data;
    end

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    wr_t exp_q[$];
    wr_t mon_e;
    int  checks   = 0;
    int  passed   = 0;
    int  wr_count = 0;

    function automatic logic [DATA_W-1:0] add_model(input logic [DATA_W-1:0] a,
                                                    input logic [DATA_W-1:0] b);
        logic [DATA_W:0] s;
        s = {1'b0, a} + {1'b0, b};
`ifdef PL_SAT_EN
        if (s[DATA_W]) return '1;
`endif
        return s[DATA_W-1:0];
    endfunction

    // Scoreboard: every write seen on the bus must match the head of the expected queue.
    always @(negedge clk) begin
        if (rst === 1'b1 && we_pl === 1'b1) begin
            wr_count++;
            checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL write_unexpected got addr=%0d data=%h expected no write",
                         address_pl, data_in_pl);
            end else begin
                mon_e = exp_q.pop_front();
                if (address_pl !== mon_e.addr || data_in_pl !== mon_e.data)
                    $display("FAIL write got addr=%0d data=%h expected addr=%0d data=%h",
                             address_pl, data_in_pl, mon_e.addr, mon_e.data);
                else
                    passed++;
            end
        end
    end

    task automatic load_word(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        ld_addr = a;
        ld_data = d;
        ld_en   = 1'b1;
        @(posedge clk);
        #1 ld_en = 1'b0;
    endtask

    // Runs one job; abort_at >= 0 drops launch_pl at the start of that cycle (cycle 0 = first RD_REQ).
    task automatic run_job(input logic [DATA_W-1:0] w0, input logic [DATA_W-1:0] w1,
                           input logic [DATA_W-1:0] w2, input logic [DATA_W-1:0] w3,
                           input int abort_at);
        logic [DATA_W-1:0] w [4];
        logic [DATA_W-1:0] acc;
        logic [ADDR_W-1:0] ea;
        int                n_exp;
        int                wr_base;
        w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
        acc   = '0;
        n_exp = (abort_at < 0) ? LEN : abort_at / 3;
        for (int i = 0; i < LEN; i++) begin
            load_word(ADDR_W'(SRC + i), w[i]);
            acc = add_model(acc, w[i]);
            if (i < n_exp) exp_q.push_back('{addr: ADDR_W'(DST + i), data: acc});
        end
        wr_base      = wr_count;
        ready_for_pl = 1'b1;
        launch_pl    = 1'b1;
        @(posedge clk);
        #1;
        for (int c = 0; c <= 3 * LEN; c++) begin
            if (c == abort_at) launch_pl = 1'b0;
            @(negedge clk);
            if ((abort_at < 0 || c <= abort_at) && (c % 3 == 0) && (c < 3 * LEN)) begin
                ea = ADDR_W'(SRC + c / 3);
                checks++;
                if (address_pl !== ea || we_pl !== 1'b0 || busy !== 1'b1)
                    $display("FAIL rd_req cycle %0d got addr=%0d we=%b busy=%b expected addr=%0d we=0 busy=1",
                             c, address_pl, we_pl, busy, ea);
                else
                    passed++;
            end
            if (abort_at >= 0 && c == abort_at + 1) begin
                checks++;
                if (busy !== 1'b0 || we_pl !== 1'b0 || finish_pl !== 1'b0)
                    $display("FAIL abort_idle got busy=%b we=%b finish=%b expected 0 0 0",
                             busy, we_pl, finish_pl);
                else
                    passed++;
            end
            if (c == 3 * LEN - 1) begin
                checks++;
                if (finish_pl !== 1'b0)
                    $display("FAIL finish_early got finish=%b expected 0 at cycle %0d", finish_pl, c);
                else
                    passed++;
            end
            if (c == 3 * LEN) begin
                checks++;
                if (finish_pl !== (abort_at < 0) || busy !== 1'b0)
                    $display("FAIL finish_cycle got finish=%b busy=%b expected finish=%b busy=0",
                             finish_pl, busy, (abort_at < 0));
                else
                    passed++;
            end
            @(posedge clk);
            #1;
        end
        launch_pl = 1'b0;
        checks++;
        if (wr_count - wr_base !== n_exp)
            $display("FAIL write_count got %0d expected %0d", wr_count - wr_base, n_exp);
        else
            passed++;
        checks++;
        if (exp_q.size() !== 0)
            $display("FAIL scoreboard_left got %0d pending expected 0", exp_q.size());
        else
            passed++;
    endtask

    // finish_pl must stay up while ready_for_pl is held, then fall one cycle after it drops.
    task automatic release_job();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (finish_pl !== 1'b1)
                $display("FAIL finish_hold got %b expected 1", finish_pl);
            else
                passed++;
        end
        @(posedge clk);
        #1 ready_for_pl = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (finish_pl !== 1'b0 || busy !== 1'b0)
            $display("FAIL finish_release got finish=%b busy=%b expected 0 0", finish_pl, busy);
        else
            passed++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (we_pl !== 1'b0) $display("FAIL reset_we got %b expected 0", we_pl); else passed++;
        checks++;
        if (address_pl !== '0) $display("FAIL reset_addr got %0d expected 0", address_pl); else passed++;
        checks++;
        if (data_in_pl !== '0) $display("FAIL reset_data got %h expected 0", data_in_pl); else passed++;
        checks++;
        if (finish_pl !== 1'b0) $display("FAIL reset_finish got %b expected 0", finish_pl); else passed++;
        checks++;
        if (busy !== 1'b0) $display("FAIL reset_busy got %b expected 0", busy); else passed++;
    endtask

    task automatic test_prefix_sum();
        run_job(32'd1, 32'd2, 32'd3, 32'd4, -1);
        release_job();
    endtask

    task automatic test_overflow();
        run_job(32'hFFFF_FFFF, 32'h2, 32'h0, 32'h0, -1);
        release_job();
    endtask

    task automatic test_abort();
        run_job(32'd5, 32'd6, 32'd7, 32'd8, 7);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (finish_pl !== 1'b0 || busy !== 1'b0)
                $display("FAIL abort_quiet got finish=%b busy=%b expected 0 0", finish_pl, busy);
            else
                passed++;
        end
        @(posedge clk);
        #1 ready_for_pl = 1'b0;
    endtask

    task automatic test_reset_mid_job();
        load_word(ADDR_W'(DST), 32'hDEAD_BEEF);
        ready_for_pl = 1'b1;
        launch_pl    = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
        end
        checks++;
        if (we_pl !== 1'b1) $display("FAIL pre_reset_wr got we=%b expected 1", we_pl); else passed++;
        #1 rst = 1'b0;
        #1;
        checks++;
        if (we_pl !== 1'b0 || address_pl !== '0 || data_in_pl !== '0 || finish_pl !== 1'b0 || busy !== 1'b0)
            $display("FAIL midjob_reset got we=%b addr=%0d data=%h finish=%b busy=%b expected all 0",
                     we_pl, address_pl, data_in_pl, finish_pl, busy);
        else
            passed++;
        launch_pl    = 1'b0;
        ready_for_pl = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        checks++;
        if (mem[DST] !== 32'hDEAD_BEEF)
            $display("FAIL midjob_nowrite got %h expected deadbeef", mem[DST]);
        else
            passed++;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || we_pl !== 1'b0 || finish_pl !== 1'b0)
            $display("FAIL midjob_idle got busy=%b we=%b finish=%b expected 0 0 0", busy, we_pl, finish_pl);
        else
            passed++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        run_job(32'd10, 32'd20, 32'd30, 32'd40, -1);
        release_job();
        run_job(32'd1, 32'd1, 32'd1, 32'd1, -1);
        release_job();
    endtask

    initial begin
        rst          = 1'b0;
        ready_for_pl = 1'b0;
        launch_pl    = 1'b0;
        ld_en        = 1'b0;
        ld_addr      = '0;
        ld_data      = '0;
        test_reset();
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        test_prefix_sum();
        test_overflow();
        test_abort();
        test_reset_mid_job();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1);
    end

endmodule
